decode: RTL and testbench

Instruction-decode stage of the single-issue RV32I core, between fetch and execute. It splits the 32-bit instruction into register-file selects, a sign-extended immediate, ALU/operand controls, memory and writeback controls. It also resolves the next-PC redirect for JAL, JALR and taken branches back to fetch.

---
 rtl/decode_pkg.sv | 53 +++++
 rtl/decode_imm_gen.sv | 23 ++
 rtl/decode.sv | 139 +++++++++++++
 tb/tb_decode.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: RV32I opcodes, ALU and operand-A encodings,
// and immediate-format extraction helpers.
package decode_pkg;

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_ALU_I  = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_AUIPC  = 7'b0010111,
        OP_LUI    = 7'b0110111
    } opcode_e;

    typedef enum logic [1:0] {
        OPA_RS1  = 2'b00,
        OPA_PC   = 2'b01,
        OPA_PC4  = 2'b10,
        OPA_ZERO = 2'b11
    } op_a_sel_e;

    localparam logic [5:0] ALU_ADD  = 6'b000000;
    localparam logic [5:0] ALU_SUB  = 6'b001000;
    localparam logic [5:0] ALU_SLT  = 6'b000010;
    localparam logic [5:0] ALU_XOR  = 6'b000100;
    localparam logic [5:0] ALU_AND  = 6'b000111;
    localparam logic [5:0] ALU_SRA  = 6'b001101;
    localparam logic [5:0] ALU_BEQ  = 6'b010000;
    localparam logic [5:0] ALU_PASS = 6'b011111;

    function automatic logic [31:0] imm_i(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:25], ins[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] ins);
        return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] ins);
        return {ins[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] ins);
        return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// Immediate generator: picks the RV32I immediate format from the opcode;
// unrecognised opcodes yield zero.
module decode_imm_gen
    import decode_pkg::*;
(
    input  logic [31:0] i_instruction,
    output logic [31:0] o_imm32
);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        o_imm32 = '0;
        case (opcode_e'(i_instruction[6:0]))
            OP_ALU_I, OP_LOAD, OP_JALR: o_imm32 = imm_i(i_instruction);
            OP_STORE:                   o_imm32 = imm_s(i_instruction);
            OP_BRANCH:                  o_imm32 = imm_b(i_instruction);
            OP_JAL:                     o_imm32 = imm_j(i_instruction);
            OP_AUIPC, OP_LUI:           o_imm32 = imm_u(i_instruction);
            default:                    o_imm32 = '0;
        endcase
    end

endmodule

// File: rtl/decode.sv
// RV32I decode stage: register selects, immediate, ALU/operand/memory/writeback
// controls and the next-PC redirect; side-effects gated by a run flag.
module decode
    import decode_pkg::*;
#(
    parameter int ADDRESS_BITS = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDRESS_BITS-1:0] PC,
    input  logic [31:0]             instruction,
    input  logic [ADDRESS_BITS-1:0] JALR_target,
    input  logic                    branch,
    output logic                    next_PC_select,
    output logic [ADDRESS_BITS-1:0] target_PC,
    output logic [4:0]              read_sel1,
    output logic [4:0]              read_sel2,
    output logic [4:0]              write_sel,
    output logic                    wEn,
    output logic                    branch_op,
    output logic [31:0]             imm32,
    output logic [1:0]              op_A_sel,
    output logic                    op_B_sel,
    output logic [5:0]              ALU_Control,
    output logic                    mem_wEn,
    output logic                    wb_sel
);

    logic                    r_run;
    logic                    w_wen;
    logic                    w_mem_wen;
    logic                    w_branch_op;
    logic                    w_jump;
    logic [31:0]             w_b_imm;
    logic [31:0]             w_j_imm;
    logic [ADDRESS_BITS-1:0] w_b_target;
    logic [ADDRESS_BITS-1:0] w_j_target;
    logic [ADDRESS_BITS-1:0] w_jalr_target;
    logic [2:0]              w_f3;

    // NOTE: asynchronous active-low clear with non-blocking update for sequential state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_run <= 1'b0;
        else        r_run <= 1'b1;
    end

    decode_imm_gen u_imm_gen (
        .i_instruction (instruction),
        .o_imm32       (imm32)
    );

    assign read_sel1 = instruction[19:15];
    assign read_sel2 = instruction[24:20];
    assign write_sel = instruction[11:7];
    assign w_f3      = instruction[14:12];

    always_comb begin
        w_wen       = 1'b0;
        w_mem_wen   = 1'b0;
        w_branch_op = 1'b0;
        w_jump      = 1'b0;
        op_A_sel    = OPA_RS1;
        op_B_sel    = 1'b0;
        wb_sel      = 1'b0;
        ALU_Control = ALU_ADD;
        case (opcode_e'(instruction[6:0]))
            OP_R: begin
                w_wen       = 1'b1;
                ALU_Control = {2'b00, instruction[30], w_f3};
            end
            OP_ALU_I: begin
                w_wen       = 1'b1;
                op_B_sel    = 1'b1;
                // bit 30 only distinguishes SRAI from SRLI; elsewhere it is immediate data
                ALU_Control = (w_f3 == 3'b101) ? {2'b00, instruction[30], w_f3}
                                               : {3'b000, w_f3};
            end
            OP_LOAD: begin
                w_wen    = 1'b1;
                op_B_sel = 1'b1;
                wb_sel   = 1'b1;
            end
            OP_STORE: begin
                w_mem_wen = 1'b1;
                op_B_sel  = 1'b1;
            end
            OP_BRANCH: begin
                w_branch_op = 1'b1;
                ALU_Control = {3'b010, w_f3};
            end
            OP_JAL: begin
                w_wen       = 1'b1;
                w_jump      = 1'b1;
                op_A_sel    = OPA_PC4;
                ALU_Control = ALU_PASS;
            end
            OP_JALR: begin
                w_wen       = 1'b1;
                w_jump      = 1'b1;
                op_A_sel    = OPA_PC4;
                op_B_sel    = 1'b1;
                ALU_Control = ALU_PASS;
            end
            OP_AUIPC: begin
                w_wen    = 1'b1;
                op_A_sel = OPA_PC;
                op_B_sel = 1'b1;
            end
            OP_LUI: begin
                w_wen    = 1'b1;
                op_A_sel = OPA_ZERO;
                op_B_sel = 1'b1;
            end
            default: ;
        endcase
    end

    // Redirect targets use their own immediates so a non-branch still yields PC + B-imm.
    assign w_b_imm       = imm_b(instruction);
    assign w_j_imm       = imm_j(instruction);
    assign w_b_target    = PC + w_b_imm[ADDRESS_BITS-1:0];
    assign w_j_target    = PC + w_j_imm[ADDRESS_BITS-1:0];
    assign w_jalr_target = {JALR_target[ADDRESS_BITS-1:1], 1'b0};

    always_comb begin
        target_PC = w_b_target;
        case (opcode_e'(instruction[6:0]))
            OP_JAL:  target_PC = w_j_target;
            OP_JALR: target_PC = w_jalr_target;
            default: target_PC = w_b_target;
        endcase
    end

    assign wEn            = r_run & w_wen;
    assign mem_wEn        = r_run & w_mem_wen;
    assign branch_op      = r_run & w_branch_op;
    assign next_PC_select = r_run & (w_jump | (w_branch_op & branch));

endmodule

// File: tb/tb_decode.sv
// Directed self-checking bench for the decode stage.
module tb_decode;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] PC;
    logic [31:0] instruction;
    logic [15:0] JALR_target;
    logic        branch;
    logic        next_PC_select;
    logic [15:0] target_PC;
    logic [4:0]  read_sel1;
    logic [4:0]  read_sel2;
    logic [4:0]  write_sel;
    logic        wEn;
    logic        branch_op;
    logic [31:0] imm32;
    logic [1:0]  op_A_sel;
    logic        op_B_sel;
    logic [5:0]  ALU_Control;
    logic        mem_wEn;
    logic        wb_sel;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    decode #(.ADDRESS_BITS(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .PC             (PC),
        .instruction    (instruction),
        .JALR_target    (JALR_target),
        .branch         (branch),
        .next_PC_select (next_PC_select),
        .target_PC      (target_PC),
        .read_sel1      (read_sel1),
        .read_sel2      (read_sel2),
        .write_sel      (write_sel),
        .wEn            (wEn),
        .branch_op      (branch_op),
        .imm32          (imm32),
        .op_A_sel       (op_A_sel),
        .op_B_sel       (op_B_sel),
        .ALU_Control    (ALU_Control),
        .mem_wEn        (mem_wEn),
        .wb_sel         (wb_sel)
    );

    task automatic drive(input logic [31:0] ins, input logic [15:0] pc,
                         input logic [15:0] jt, input logic br);
        instruction = ins;
        PC          = pc;
        JALR_target = jt;
        branch      = br;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        drive(32'h00C5A023, 16'h0000, 16'h0000, 1'b0);
        total++; if (mem_wEn !== 1'b0) begin bad++; $display("FAIL reset_mem_wEn got=%b exp=0", mem_wEn); end
        total++; if (wEn !== 1'b0) begin bad++; $display("FAIL reset_wEn got=%b exp=0", wEn); end
        total++; if (read_sel2 !== 5'd12) begin bad++; $display("FAIL reset_read_sel2 got=%0d exp=12", read_sel2); end
        total++; if (op_B_sel !== 1'b1) begin bad++; $display("FAIL reset_op_B_sel got=%b exp=1", op_B_sel); end
        @(negedge clock);
        reset = 1'b1;
        #1;
        total++; if (mem_wEn !== 1'b0) begin bad++; $display("FAIL pre_edge_mem_wEn got=%b exp=0", mem_wEn); end
        @(posedge clock);
        #1;
        total++; if (mem_wEn !== 1'b1) begin bad++; $display("FAIL run_mem_wEn got=%b exp=1", mem_wEn); end
        total++; if (wEn !== 1'b0) begin bad++; $display("FAIL store_wEn got=%b exp=0", wEn); end
    endtask

    task automatic test_alu_ops;
        drive(32'hFFF00593, 16'h0000, 16'h0000, 1'b0);   // addi a1,zero,-1
        total++; if (imm32 !== 32'hFFFFFFFF) begin bad++; $display("FAIL addi_imm got=%h exp=ffffffff", imm32); end
        total++; if (write_sel !== 5'd11) begin bad++; $display("FAIL addi_write_sel got=%0d exp=11", write_sel); end
        total++; if (wEn !== 1'b1) begin bad++; $display("FAIL addi_wEn got=%b exp=1", wEn); end
        total++; if (op_B_sel !== 1'b1) begin bad++; $display("FAIL addi_op_B got=%b exp=1", op_B_sel); end
        total++; if (ALU_Control !== 6'b000000) begin bad++; $display("FAIL addi_alu got=%b exp=000000", ALU_Control); end
        drive(32'h40E608B3, 16'h0000, 16'h0000, 1'b0);   // sub a7,a2,a4
        total++; if (read_sel1 !== 5'd12) begin bad++; $display("FAIL sub_rs1 got=%0d exp=12", read_sel1); end
        total++; if (read_sel2 !== 5'd14) begin bad++; $display("FAIL sub_rs2 got=%0d exp=14", read_sel2); end
        total++; if (write_sel !== 5'd17) begin bad++; $display("FAIL sub_rd got=%0d exp=17", write_sel); end
        total++; if (ALU_Control !== 6'b001000) begin bad++; $display("FAIL sub_alu got=%b exp=001000", ALU_Control); end
        total++; if (op_B_sel !== 1'b0) begin bad++; $display("FAIL sub_op_B got=%b exp=0", op_B_sel); end
        total++; if (op_A_sel !== 2'b00) begin bad++; $display("FAIL sub_op_A got=%b exp=00", op_A_sel); end
        drive(32'h4015D593, 16'h0000, 16'h0000, 1'b0);   // srai a1,a1,1
        total++; if (ALU_Control !== 6'b001101) begin bad++; $display("FAIL srai_alu got=%b exp=001101", ALU_Control); end
        total++; if (imm32 !== 32'h00000401) begin bad++; $display("FAIL srai_imm got=%h exp=00000401", imm32); end
        drive(32'h40000513, 16'h0000, 16'h0000, 1'b0);   // addi a0,zero,0x400: bit 30 must not turn ADD into SUB
        total++; if (ALU_Control !== 6'b000000) begin bad++; $display("FAIL addi_bit30_alu got=%b exp=000000", ALU_Control); end
    endtask

    task automatic test_mem_ops;
        drive(32'h00C5A023, 16'h0000, 16'h0000, 1'b0);   // sw a2,0(a1)
        total++; if (mem_wEn !== 1'b1) begin bad++; $display("FAIL sw_mem_wEn got=%b exp=1", mem_wEn); end
        total++; if (wEn !== 1'b0) begin bad++; $display("FAIL sw_wEn got=%b exp=0", wEn); end
        total++; if (imm32 !== 32'h0) begin bad++; $display("FAIL sw_imm got=%h exp=00000000", imm32); end
        drive(32'hFE112E23, 16'h0000, 16'h0000, 1'b0);   // sw ra,-4(sp)
        total++; if (imm32 !== 32'hFFFFFFFC) begin bad++; $display("FAIL sw_neg_imm got=%h exp=fffffffc", imm32); end
        drive(32'h0005A903, 16'h0000, 16'h0000, 1'b0);   // lw s2,0(a1)
        total++; if (wb_sel !== 1'b1) begin bad++; $display("FAIL lw_wb_sel got=%b exp=1", wb_sel); end
        total++; if (wEn !== 1'b1) begin bad++; $display("FAIL lw_wEn got=%b exp=1", wEn); end
        total++; if (mem_wEn !== 1'b0) begin bad++; $display("FAIL lw_mem_wEn got=%b exp=0", mem_wEn); end
    endtask

    task automatic test_jumps;
        drive(32'h0140006F, 16'h0114, 16'h0000, 1'b0);   // jal zero,+20
        total++; if (target_PC !== 16'h0128) begin bad++; $display("FAIL jal_target got=%h exp=0128", target_PC); end
        total++; if (next_PC_select !== 1'b1) begin bad++; $display("FAIL jal_npc got=%b exp=1", next_PC_select); end
        total++; if (op_A_sel !== 2'b10) begin bad++; $display("FAIL jal_op_A got=%b exp=10", op_A_sel); end
        total++; if (ALU_Control !== 6'b011111) begin bad++; $display("FAIL jal_alu got=%b exp=011111", ALU_Control); end
        drive(32'h0140006F, 16'hFFF0, 16'h0000, 1'b0);   // wraps past the top of the address space
        total++; if (target_PC !== 16'h0004) begin bad++; $display("FAIL jal_wrap got=%h exp=0004", target_PC); end
        drive(32'h0C4080E7, 16'h0000, 16'h0154, 1'b0);   // jalr
        total++; if (target_PC !== 16'h0154) begin bad++; $display("FAIL jalr_target got=%h exp=0154", target_PC); end
        total++; if (next_PC_select !== 1'b1) begin bad++; $display("FAIL jalr_npc got=%b exp=1", next_PC_select); end
        total++; if (op_B_sel !== 1'b1) begin bad++; $display("FAIL jalr_op_B got=%b exp=1", op_B_sel); end
        drive(32'h0C4080E7, 16'h0000, 16'h0155, 1'b0);   // odd target, bit 0 cleared
        total++; if (target_PC !== 16'h0154) begin bad++; $display("FAIL jalr_lsb got=%h exp=0154", target_PC); end
    endtask

    task automatic test_branch;
        drive(32'h00208863, 16'h0004, 16'h0000, 1'b1);   // beq x1,x2,+16 taken
        total++; if (target_PC !== 16'h0014) begin bad++; $display("FAIL beq_target got=%h exp=0014", target_PC); end
        total++; if (next_PC_select !== 1'b1) begin bad++; $display("FAIL beq_taken_npc got=%b exp=1", next_PC_select); end
        total++; if (ALU_Control !== 6'b010000) begin bad++; $display("FAIL beq_alu got=%b exp=010000", ALU_Control); end
        total++; if (branch_op !== 1'b1) begin bad++; $display("FAIL beq_branch_op got=%b exp=1", branch_op); end
        total++; if (wEn !== 1'b0) begin bad++; $display("FAIL beq_wEn got=%b exp=0", wEn); end
        drive(32'h00208863, 16'h0004, 16'h0000, 1'b0);   // not taken
        total++; if (next_PC_select !== 1'b0) begin bad++; $display("FAIL beq_nt_npc got=%b exp=0", next_PC_select); end
        drive(32'hFE208EE3, 16'h0020, 16'h0000, 1'b1);   // beq x1,x2,-4
        total++; if (target_PC !== 16'h001C) begin bad++; $display("FAIL beq_back_target got=%h exp=001c", target_PC); end
        total++; if (imm32 !== 32'hFFFFFFFC) begin bad++; $display("FAIL beq_back_imm got=%h exp=fffffffc", imm32); end
        drive(32'h00208863, 16'h0004, 16'h0000, 1'b1);
        drive(32'hFFF00593, 16'h0004, 16'h0000, 1'b1);   // branch flag alone must not redirect
        total++; if (next_PC_select !== 1'b0) begin bad++; $display("FAIL addi_branch_npc got=%b exp=0", next_PC_select); end
    endtask

    task automatic test_upper;
        drive(32'hABBBB197, 16'h0000, 16'h0000, 1'b0);   // auipc gp,0xabbbb
        total++; if (imm32 !== 32'hABBBB000) begin bad++; $display("FAIL auipc_imm got=%h exp=abbbb000", imm32); end
        total++; if (op_A_sel !== 2'b01) begin bad++; $display("FAIL auipc_op_A got=%b exp=01", op_A_sel); end
        total++; if (write_sel !== 5'd3) begin bad++; $display("FAIL auipc_rd got=%0d exp=3", write_sel); end
        drive(32'h12345537, 16'h0000, 16'h0000, 1'b0);   // lui a0,0x12345
        total++; if (imm32 !== 32'h12345000) begin bad++; $display("FAIL lui_imm got=%h exp=12345000", imm32); end
        total++; if (op_A_sel !== 2'b11) begin bad++; $display("FAIL lui_op_A got=%b exp=11", op_A_sel); end
        total++; if (wEn !== 1'b1) begin bad++; $display("FAIL lui_wEn got=%b exp=1", wEn); end
    endtask

    task automatic test_unknown;
        drive(32'hFFFFFFFF, 16'h0010, 16'h0000, 1'b1);   // opcode 1111111
        total++; if (wEn !== 1'b0) begin bad++; $display("FAIL unk_wEn got=%b exp=0", wEn); end
        total++; if (mem_wEn !== 1'b0) begin bad++; $display("FAIL unk_mem_wEn got=%b exp=0", mem_wEn); end
        total++; if (branch_op !== 1'b0) begin bad++; $display("FAIL unk_branch_op got=%b exp=0", branch_op); end
        total++; if (next_PC_select !== 1'b0) begin bad++; $display("FAIL unk_npc got=%b exp=0", next_PC_select); end
        total++; if (imm32 !== 32'h0) begin bad++; $display("FAIL unk_imm got=%h exp=00000000", imm32); end
        total++; if (ALU_Control !== 6'b000000) begin bad++; $display("FAIL unk_alu got=%b exp=000000", ALU_Control); end
        total++; if (target_PC !== 16'h000E) begin bad++; $display("FAIL unk_target got=%h exp=000e", target_PC); end
    endtask

    task automatic test_reset_mid_instr;
        drive(32'h0140006F, 16'h0114, 16'h0000, 1'b0);
        total++; if (next_PC_select !== 1'b1) begin bad++; $display("FAIL mid_pre_npc got=%b exp=1", next_PC_select); end
        reset = 1'b0;
        #1;
        total++; if (next_PC_select !== 1'b0) begin bad++; $display("FAIL mid_npc got=%b exp=0", next_PC_select); end
        total++; if (wEn !== 1'b0) begin bad++; $display("FAIL mid_wEn got=%b exp=0", wEn); end
        total++; if (target_PC !== 16'h0128) begin bad++; $display("FAIL mid_target got=%h exp=0128", target_PC); end
        total++; if (op_A_sel !== 2'b10) begin bad++; $display("FAIL mid_op_A got=%b exp=10", op_A_sel); end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        total++; if (wEn !== 1'b1) begin bad++; $display("FAIL mid_resume_wEn got=%b exp=1", wEn); end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_mem_ops();
        test_jumps();
        test_branch();
        test_upper();
        test_unknown();
        test_reset_mid_instr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
